// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 transaction sequencer.
// States, error codes, frame length and the checksum helper.
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_LOW,
        RELEASE,
        ACK_LOW,
        ACK_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK
    } state_e;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_NORESP = 2'd1;
    localparam logic [1:0] ERR_BITTO  = 2'd2;
    localparam logic [1:0] ERR_CKSUM  = 2'd3;

    localparam int FRAME_BITS = 40;

    // Frame is {b0,b1,b2,b3,b4}, b0 in the top byte.
    function automatic logic [7:0] frame_sum(input logic [39:0] f);
        return f[39:32] + f[31:24] + f[23:16] + f[15:8];
    endfunction

endpackage

// File: rtl/dht11_sequencer_us_tick_gen.sv
// Free-running divider: one-cycle tick every CLK_FREQ/1e6 clocks.
// Asynchronous active-high reset.
module us_tick_gen #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int DIV = CLK_FREQ / 1_000_000;
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/dht11_sequencer.sv
// DHT11 single-wire transaction sequencer with checksum validation.
// Optional self-trigger: define DHT_AUTO_TRIG_EN.
module dht11_sequencer
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int START_LOW_US   = 18000,
    parameter int TIMEOUT_US     = 200,
    parameter int BIT_THRESH_US  = 40,
    parameter int AUTO_PERIOD_MS = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dht_in,
    output logic       dht_drive_low,
    output logic [7:0] rh_data,
    output logic [7:0] t_data,
    output logic       valid,
    output logic       busy,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int MAXUS = (START_LOW_US > TIMEOUT_US) ?
                           START_LOW_US : TIMEOUT_US;
    localparam int UW = $clog2(MAXUS + BIT_THRESH_US + 2);

    localparam logic [UW-1:0] START_CNT  = UW'(START_LOW_US);
    localparam logic [UW-1:0] TO_CNT     = UW'(TIMEOUT_US);
    localparam logic [UW-1:0] THRESH_CNT = UW'(BIT_THRESH_US);
    localparam logic [5:0]    LAST_BIT   = 6'(FRAME_BITS - 1);

    state_e      state_q, state_d;
    logic [1:0]  sync_q;
    logic        prev_q;
    logic [UW-1:0] us_q, us_d;
    logic [39:0] shift_q, shift_d;
    logic [5:0]  bits_q, bits_d;
    logic [7:0]  rh_q, rh_d;
    logic [7:0]  t_q, t_d;
    logic [1:0]  err_q, err_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        tick;
    logic        rose;
    logic        fell;
    logic        timed_out;
    logic        trig;
    logic        auto_trig;

    us_tick_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick_o(tick)
    );

    assign rose      = sync_q[1] & ~prev_q;
    assign fell      = ~sync_q[1] & prev_q;
    assign timed_out = (us_q >= TO_CNT);
    assign trig      = start | auto_trig;

`ifdef DHT_AUTO_TRIG_EN
    localparam int MW = $clog2(AUTO_PERIOD_MS + 1);
    localparam logic [MW-1:0] PERIOD = MW'(AUTO_PERIOD_MS);

    logic [9:0]    sub_q, sub_d;
    logic [MW-1:0] ms_q, ms_d;

    // Period only runs while idle; an external start restarts it.
    always_comb begin
        sub_d = sub_q;
        ms_d  = ms_q;
        if (state_q != IDLE || start) begin
            sub_d = '0;
            ms_d  = '0;
        end else if (tick && ms_q != PERIOD) begin
            if (sub_q == 10'd999) begin
                sub_d = '0;
                ms_d  = ms_q + 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_q <= '0;
            ms_q  <= '0;
        end else begin
            sub_q <= sub_d;
            ms_q  <= ms_d;
        end
    end

    assign auto_trig = (state_q == IDLE) && (ms_q == PERIOD);
`else
    assign auto_trig = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bits_d  = bits_q;
        rh_d    = rh_q;
        t_d     = t_q;
        err_d   = err_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = START_LOW;
                    shift_d = '0;
                    bits_d  = '0;
                end
            end
            START_LOW: begin
                if (us_q >= START_CNT) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (fell) begin
                    state_d = ACK_LOW;
                end else if (timed_out) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    err_d   = ERR_NORESP;
                end
            end
            ACK_LOW: begin
                if (rose) begin
                    state_d = ACK_HIGH;
                end else if (timed_out) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    err_d   = ERR_NORESP;
                end
            end
            ACK_HIGH: begin
                if (fell) begin
                    state_d = BIT_LOW;
                end else if (timed_out) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    err_d   = ERR_NORESP;
                end
            end
            BIT_LOW: begin
                if (rose) begin
                    state_d = BIT_HIGH;
                end else if (timed_out) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    err_d   = ERR_BITTO;
                end
            end
            BIT_HIGH: begin
                if (fell) begin
                    shift_d = {shift_q[38:0], (us_q > THRESH_CNT)};
                    bits_d  = bits_q + 1'b1;
                    state_d = (bits_q == LAST_BIT) ? CHECK : BIT_LOW;
                end else if (timed_out) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    err_d   = ERR_BITTO;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (frame_sum(shift_q) == shift_q[7:0]) begin
                    rh_d    = shift_q[39:32];
                    t_d     = shift_q[23:16];
                    valid_d = 1'b1;
                    err_d   = ERR_NONE;
                end else begin
                    error_d = 1'b1;
                    err_d   = ERR_CKSUM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Microsecond counter restarts on every state change.
    always_comb begin
        us_d = us_q;
        if (state_d != state_q) begin
            us_d = '0;
        end else if (tick && state_q != IDLE) begin
            us_d = us_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            us_q    <= '0;
            shift_q <= '0;
            bits_q  <= '0;
            rh_q    <= '0;
            t_q     <= '0;
            err_q   <= ERR_NONE;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], dht_in};
            prev_q  <= sync_q[1];
            us_q    <= us_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            rh_q    <= rh_d;
            t_q     <= t_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign dht_drive_low = (state_q == START_LOW);
    assign busy          = (state_q != IDLE);
    assign rh_data       = rh_q;
    assign t_data        = t_q;
    assign valid         = valid_q;
    assign error         = error_q;
    assign err_code      = err_q;

endmodule

// File: doc/dht11_sequencer.md
Name: dht11_sequencer

Overview:
Sequences DHT11 single-wire transactions and delivers validated humidity and temperature bytes to the FND display path. Each transaction runs: host start pulse, sensor handshake, 40-bit capture, checksum check. On success it updates the held `rh_data`/`t_data` registers. On failure it reports an error code and leaves the previous values untouched. It sits between the sensor pin and the 4-digit display controller.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz; used to derive the 1 us tick.
- START_LOW_US, 18000, duration the host holds the line low to start a transaction.
- TIMEOUT_US, 200, maximum time allowed in any wait-for-edge state.
- BIT_THRESH_US, 40, data-high width threshold: a width strictly greater than this decodes as 1.
- AUTO_PERIOD_MS, 2000, self-trigger period (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to begin a transaction; ignored while busy.
- dht_in  in  1  raw sensor line level (asynchronous input).
- dht_drive_low  out  1  1 = open-drain pulls the line low; 0 = release (pull-up).
- rh_data  out  8  last valid humidity integer byte.
- t_data  out  8  last valid temperature integer byte.
- valid  out  1  one-cycle pulse when rh_data/t_data update.
- busy  out  1  high from accepted start until return to IDLE.
- error  out  1  one-cycle pulse on a failed transaction.
- err_code  out  2  cause of the last failure, held: 0 none, 1 no response, 2 bit timeout, 3 checksum.

Behaviour:
- Reset values: dht_drive_low=0, rh_data=0, t_data=0, valid=0, busy=0, error=0, err_code=0, state=IDLE.
- dht_in passes through a 2-FF synchronizer. All edge detection uses the synchronized value, so there is 2 cycles of latency.
- A 1 us tick is generated internally (CLK_FREQ/1_000_000 cycles). A us counter clears on every state entry.
- State machine:
  - IDLE: on start go to START_LOW and set busy=1. A start pulse while busy is dropped, not queued.
  - START_LOW: drive_low=1 for START_LOW_US, then go to RELEASE with drive_low=0.
  - RELEASE: wait for dht_in falling edge, then go to ACK_LOW. If us counter reaches TIMEOUT_US: error code 1.
  - ACK_LOW: wait for rising edge, then ACK_HIGH. Timeout gives code 1.
  - ACK_HIGH: wait for falling edge, then BIT_LOW. Timeout gives code 1.
  - BIT_LOW: wait for rising edge, then BIT_HIGH. Timeout gives code 2.
  - BIT_HIGH: on falling edge, shift in bit = (us_count > BIT_THRESH_US), MSB first, and increment bit_cnt. If bit_cnt reaches 40 go to CHECK, else BIT_LOW. Timeout gives code 2.
  - CHECK (1 cycle): sum = (b0+b1+b2+b3) mod 256.
    - If sum == b4: rh_data=b0, t_data=b2, valid=1, err_code=0.
    - Else: error=1, err_code=3, outputs hold.
    - Then go to IDLE and set busy=0.
  - On any timeout: error=1, set err_code, go to IDLE, busy=0, drive_low=0. rh_data/t_data hold.
- The 40-bit shift register and bit_cnt clear when START_LOW is entered.
- Reset mid-transaction aborts immediately and releases the line (drive_low=0).
- valid and error are never asserted in the same cycle.

Optional Feature:
- Macro `DHT_AUTO_TRIG_EN`.
- Defined: an internal ms counter generates an implicit start every AUTO_PERIOD_MS while in IDLE. The first trigger occurs AUTO_PERIOD_MS after reset release. An external start is still accepted and restarts the period counter.
- Undefined: transactions begin only on the start port, and the period counter is not synthesized.

Decomposition:
- Package `dht11_pkg` holds:
  - the state enum (IDLE, START_LOW, RELEASE, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, CHECK);
  - err_code constants (ERR_NONE, ERR_NORESP, ERR_BITTO, ERR_CKSUM);
  - the frame-length constant 40.
- One sub-module, `us_tick_gen`: counter producing a 1-cycle tick every CLK_FREQ/1e6 cycles, with asynchronous reset.

Test Plan:
1. Sensor model replies with frame 0x37 0x00 0x19 0x00 0x50 (0-bit high 26 us, 1-bit high 70 us), start pulsed → drive_low high for 18 ms; then valid pulses once with rh_data=55 (0x37), t_data=25 (0x19), err_code=0, busy falls in the same cycle.
2. Same frame with checksum byte 0x51 → error pulse, err_code=3, rh_data/t_data keep their values from test 1.
3. No sensor response (line stays high after release) → error pulses 200 us after release, err_code=1, busy=0.
4. Sensor stops after 12 bits (line stuck high) → err_code=2 after 200 us in BIT_HIGH; a subsequent good frame 0x28 0x00 0x1E 0x00 0x46 gives rh_data=40, t_data=30.
5. A second start pulsed during BIT_LOW, then reset asserted mid-frame → the second start has no effect; reset clears all outputs to 0 and drive_low=0 within 1 cycle of reset.
6. With DHT_AUTO_TRIG_EN, AUTO_PERIOD_MS=5 and no start → START_LOW entered at 5 ms and again 5 ms after each return to IDLE.
